// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Takes decoded RV32I/M instruction fields over a valid/ready handshake,
//   assembles the 32-bit instruction word and writes the words one after
//   another into instruction memory through a registered write port. It is
//   used to load a program before the core is released.
//
// Optional feature (compile-time macro NOP_PAD_EN):
//   defined   - after the last write a PAD state fills every remaining word
//               with NOP (0x00000013), one per cycle, until memory is full,
//               and then enters DONE.
//   undefined - DONE follows the last write directly.
//
// Ports:
//   clk         system clock
//   arst_n      asynchronous active-low reset
//   start       pulse: clear counter, errors and pointer, enter LOAD
//   req_valid   request present
//   req_ready   request accepted this cycle when high together with req_valid
//   req_op      class: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH_EQ,
//               5 JUMP, 6 MUL, 7 undefined
//   req_funct3  funct3 field
//   req_rd      destination register
//   req_rs1     source register 1
//   req_rs2     source register 2
//   req_imm     signed immediate (byte offset for BRANCH_EQ / JUMP)
//   req_last    final instruction of the program
//   imem_we     instruction-memory write enable (one pulse per word)
//   imem_addr   word address
//   imem_wdata  encoded instruction
//   busy        high in LOAD (and PAD)
//   done        high in DONE
//   count       words written since start (saturates at 2**ADDR_W)
//   err_full    sticky: request presented while memory full
//   err_op      sticky: undefined req_op accepted
module instr_encoder_loader #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [20:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_full,
  output logic              err_op
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

`ifdef NOP_PAD_EN
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                err_full_reg, err_full_next;
  logic                err_op_reg, err_op_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;

  logic                full;
  logic                accept;
  logic [31:0]         enc_word;

  // Field assembly for each instruction class; unused fields stay zero.
  always_comb begin
    enc_word = '0;
    case (req_op)
      3'd0: enc_word = {7'b0000000, req_rs2, req_rs1, req_funct3, req_rd, OPC_OP};
      3'd1: enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OP_IMM};
      3'd2: enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
      3'd3: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_STORE};
      3'd4: enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                        req_imm[4:1], req_imm[11], OPC_BRANCH};
      3'd5: enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                        req_rd, OPC_JAL};
      3'd6: enc_word = {7'b0000001, req_rs2, req_rs1, req_funct3, req_rd, OPC_OP};
      default: enc_word = '0;
    endcase
  end

  assign full      = (count_reg == CAPACITY);
  // start wins over a coincident request, so it is never accepted.
  assign req_ready = (state_reg == S_LOAD) && !full && !start;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    count_next    = count_reg;
    err_full_next = err_full_reg;
    err_op_next   = err_op_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;

    if (start) begin
      state_next    = S_LOAD;
      ptr_next      = BASE_ADDR;
      count_next    = '0;
      err_full_next = 1'b0;
      err_op_next   = 1'b0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (req_valid && full) begin
            err_full_next = 1'b1;
          end
          if (accept) begin
            if (req_op != 3'd7) begin
              we_next    = 1'b1;
              addr_next  = ptr_reg;
              wdata_next = enc_word;
              ptr_next   = ptr_reg + 1'b1;
              count_next = full ? count_reg : count_reg + 1'b1;
            end else begin
              err_op_next = 1'b1;
            end
            if (req_last) begin
`ifdef NOP_PAD_EN
              // Skip PAD entirely when this word already filled the memory.
              state_next = (count_next == CAPACITY) ? S_DONE : S_PAD;
`else
              state_next = S_DONE;
`endif
            end
          end
        end
`ifdef NOP_PAD_EN
        S_PAD: begin
          if (full) begin
            state_next = S_DONE;
          end else begin
            we_next    = 1'b1;
            addr_next  = ptr_reg;
            wdata_next = NOP_WORD;
            ptr_next   = ptr_reg + 1'b1;
            count_next = count_reg + 1'b1;
            // Leave together with the final pad write.
            if (count_next == CAPACITY) begin
              state_next = S_DONE;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= BASE_ADDR;
      count_reg    <= '0;
      err_full_reg <= 1'b0;
      err_op_reg   <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      count_reg    <= count_next;
      err_full_reg <= err_full_next;
      err_op_reg   <= err_op_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign count      = count_reg;
  assign err_full   = err_full_reg;
  assign err_op     = err_op_reg;
  assign done       = (state_reg == S_DONE);
`ifdef NOP_PAD_EN
  assign busy       = (state_reg == S_LOAD) || (state_reg == S_PAD);
`else
  assign busy       = (state_reg == S_LOAD);
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (default build, NOP_PAD_EN
// undefined). Two instances share all inputs: a 64-word one and a 4-word
// one (ADDR_W=2) for the full boundary. A reference model computes the
// expected handshake and write stream from the field rules directly.
module tb_instr_encoder_loader;

  typedef struct packed {
    logic        st;
    logic        v;
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
    logic        last;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, start, req_valid, req_last;
  logic [2:0]  req_op, req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [20:0] req_imm;

  logic        b_ready, b_we, b_busy, b_done, b_err_full, b_err_op;
  logic [5:0]  b_addr;
  logic [31:0] b_wdata;
  logic [6:0]  b_count;
  logic        s_ready, s_we, s_busy, s_done, s_err_full, s_err_op;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  instr_encoder_loader #(.ADDR_W(6)) dut_big (
    .clk(clk), .arst_n(arst_n), .start(start), .req_valid(req_valid), .req_ready(b_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy), .done(b_done),
    .count(b_count), .err_full(b_err_full), .err_op(b_err_op));

  instr_encoder_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .arst_n(arst_n), .start(start), .req_valid(req_valid), .req_ready(s_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last), .imem_we(s_we),
    .imem_addr(s_addr), .imem_wdata(s_wdata), .busy(s_busy), .done(s_done),
    .count(s_count), .err_full(s_err_full), .err_op(s_err_op));

  // Instance under observation: 0 = 64-word, 1 = 4-word.
  int sel = 0;
  logic        o_ready, o_we, o_busy, o_done, o_err_full, o_err_op;
  logic [31:0] o_addr, o_wdata, o_count;
  always_comb begin
    o_ready    = (sel != 0) ? s_ready    : b_ready;
    o_we       = (sel != 0) ? s_we       : b_we;
    o_busy     = (sel != 0) ? s_busy     : b_busy;
    o_done     = (sel != 0) ? s_done     : b_done;
    o_err_full = (sel != 0) ? s_err_full : b_err_full;
    o_err_op   = (sel != 0) ? s_err_op   : b_err_op;
    o_addr     = (sel != 0) ? 32'(s_addr)  : 32'(b_addr);
    o_wdata    = (sel != 0) ? s_wdata      : b_wdata;
    o_count    = (sel != 0) ? 32'(s_count) : 32'(b_count);
  end

  // Reference model: 0 idle, 1 loading, 2 done.
  int          m_state, m_count, m_ptr, cap;
  bit          m_err_full, m_err_op, m_we;
  logic [31:0] m_addr, m_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction word built from the ISA field positions with shifts/masks.
  function automatic logic [31:0] ref_encode(input req_t r);
    logic [31:0] im, rd, rs1, rs2, f3;
    im  = 32'(signed'(r.imm));
    rd  = 32'(r.rd);
    rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2);
    f3  = 32'(r.f3);
    case (r.op)
      3'd0: return 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20);
      3'd6: return 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (32'h1 << 25);
      3'd1: return 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((im & 32'hFFF) << 20);
      3'd2: return 32'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((im & 32'hFFF) << 20);
      3'd3: return 32'h23 | ((im & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                   | (((im >> 5) & 32'h7F) << 25);
      3'd4: return 32'h63 | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                   | (rs1 << 15) | (rs2 << 20) | (((im >> 5) & 32'h3F) << 25)
                   | (((im >> 12) & 32'h1) << 31);
      3'd5: return 32'h6F | (rd << 7) | (((im >> 12) & 32'hFF) << 12)
                   | (((im >> 11) & 32'h1) << 20) | (((im >> 1) & 32'h3FF) << 21)
                   | (((im >> 20) & 32'h1) << 31);
      default: return 32'h0;
    endcase
  endfunction

  function automatic req_t mk(input int op, input int f3, input int rd, input int rs1,
                              input int rs2, input int imm, input bit last);
    req_t r;
    r.st = 1'b0; r.v = 1'b1; r.op = 3'(op); r.f3 = 3'(f3); r.rd = 5'(rd);
    r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 21'(imm); r.last = last;
    return r;
  endfunction

  function automatic req_t mk_start();
    req_t r;
    r = '0;
    r.st = 1'b1;
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.st   = ($urandom_range(0, 29) == 0);
    r.v    = ($urandom_range(0, 3) != 0);
    r.op   = 3'($urandom_range(0, 7));
    r.f3   = 3'($urandom_range(0, 7));
    r.rd   = 5'($urandom_range(0, 31));
    r.rs1  = 5'($urandom_range(0, 31));
    r.rs2  = 5'($urandom_range(0, 31));
    r.imm  = 21'($urandom);
    r.last = ($urandom_range(0, 24) == 0);
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_ptr = 0;
    m_err_full = 0; m_err_op = 0; m_we = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".imem_we"}, 32'(o_we), 32'(m_we));
    if (m_we) begin
      check_eq({ctx, ".imem_addr"}, o_addr, m_addr);
      check_eq({ctx, ".imem_wdata"}, o_wdata, m_wdata);
    end
    check_eq({ctx, ".count"}, o_count, 32'(m_count));
    check_eq({ctx, ".busy"}, 32'(o_busy), 32'(m_state == 1));
    check_eq({ctx, ".done"}, 32'(o_done), 32'(m_state == 2));
    check_eq({ctx, ".err_full"}, 32'(o_err_full), 32'(m_err_full));
    check_eq({ctx, ".err_op"}, 32'(o_err_op), 32'(m_err_op));
  endtask

  // One clock cycle: drive at the falling edge, check ready combinationally,
  // advance the model, then check registered outputs at the next falling edge.
  task automatic cyc(input req_t r);
    bit full, exp_ready;
    start = r.st; req_valid = r.v; req_op = r.op; req_funct3 = r.f3; req_rd = r.rd;
    req_rs1 = r.rs1; req_rs2 = r.rs2; req_imm = r.imm; req_last = r.last;
    #1;
    full      = (m_count == cap);
    exp_ready = (m_state == 1) && !full && !r.st;
    check_eq("req_ready", 32'(o_ready), 32'(exp_ready));
    m_we = 0;
    if (r.st) begin
      m_state = 1; m_count = 0; m_ptr = 0; m_err_full = 0; m_err_op = 0;
    end else if (m_state == 1) begin
      if (r.v && full) m_err_full = 1;
      if (r.v && exp_ready) begin
        if (r.op == 3'd7) begin
          m_err_op = 1;
          $display("txn dut=%0d op=7 undefined, no write", sel);
        end else begin
          m_we    = 1;
          m_addr  = 32'(m_ptr);
          m_wdata = ref_encode(r);
          m_ptr   = (m_ptr + 1) % cap;
          if (m_count < cap) m_count++;
          $display("txn dut=%0d op=%0d addr=%0d wdata=0x%08h", sel, r.op, m_addr, m_wdata);
        end
        if (r.last) m_state = 2;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    start = 0; req_valid = 0; req_last = 0;
    @(posedge clk);
    #2;
    arst_n = 0;
    #1;
    model_reset();
    check_outputs("reset");
    check_eq("reset.imem_addr", o_addr, 32'h0);
    check_eq("reset.imem_wdata", o_wdata, 32'h0);
    check_eq("reset.req_ready", 32'(o_ready), 32'h0);
    @(negedge clk);
    arst_n = 1;
  endtask

  initial begin
    arst_n = 0; start = 0; req_valid = 0; req_op = 0; req_funct3 = 0; req_rd = 0;
    req_rs1 = 0; req_rs2 = 0; req_imm = 0; req_last = 0;
    sel = 0; cap = 64;
    do_reset();

    // Directed vectors on the 64-word instance.
    cyc(mk_start());
    cyc(mk(0, 0, 3, 1, 2, 0, 0));
    check_eq("add.wdata", o_wdata, 32'h002081B3);
    check_eq("add.addr", o_addr, 32'h0);
    check_eq("add.count", o_count, 32'd1);

    cyc(mk_start());
    cyc(mk(6, 0, 5, 6, 7, 0, 0));
    check_eq("mul.wdata", o_wdata, 32'h027302B3);
    check_eq("mul.addr", o_addr, 32'h0);
    cyc(mk(2, 2, 4, 0, 0, 8, 0));
    check_eq("lw.wdata", o_wdata, 32'h00802203);
    check_eq("lw.addr", o_addr, 32'h1);

    cyc(mk_start());
    cyc(mk(3, 2, 0, 0, 4, 12, 0));
    check_eq("sw.wdata", o_wdata, 32'h00402623);
    cyc(mk(4, 0, 0, 1, 2, -8, 1));
    check_eq("beq.wdata", o_wdata, 32'hFE208CE3);
    check_eq("beq.done", 32'(o_done), 32'h1);
    check_eq("beq.count", o_count, 32'd2);
    cyc('0);
    check_eq("after_last.we", 32'(o_we), 32'h0);

    // Undefined op: accepted, flagged, nothing written.
    cyc(mk_start());
    cyc(mk(0, 0, 1, 1, 1, 0, 0));
    cyc(mk(7, 0, 1, 1, 1, 0, 0));
    check_eq("op7.err_op", 32'(o_err_op), 32'h1);
    check_eq("op7.we", 32'(o_we), 32'h0);
    check_eq("op7.count", o_count, 32'd1);
    cyc(mk_start());
    check_eq("op7_clr.err_op", 32'(o_err_op), 32'h0);
    check_eq("op7_clr.count", o_count, 32'd0);

    // Full boundary on the 4-word instance.
    sel = 1; cap = 4;
    cyc(mk_start());
    for (int i = 0; i < 4; i++) begin
      cyc(mk(1, 0, i + 1, 0, 0, i, 0));
      check_eq("fill.addr", o_addr, 32'(i));
    end
    cyc(mk(1, 0, 9, 0, 0, 9, 0));
    check_eq("full.ready", 32'(o_ready), 32'h0);
    check_eq("full.err_full", 32'(o_err_full), 32'h1);
    check_eq("full.we", 32'(o_we), 32'h0);
    check_eq("full.count", o_count, 32'd4);
    cyc(mk(1, 0, 9, 0, 0, 9, 1));
    check_eq("full.busy", 32'(o_busy), 32'h1);

    // Reset arriving while a write is on the port.
    sel = 0; cap = 64;
    cyc(mk_start());
    start = 0; req_valid = 1; req_op = 3'd0; req_funct3 = 0; req_rd = 3; req_rs1 = 1;
    req_rs2 = 2; req_imm = 0; req_last = 0;
    @(posedge clk);
    #1;
    check_eq("pre_rst.we", 32'(o_we), 32'h1);
    req_valid = 0;
    arst_n = 0;
    #1;
    model_reset();
    check_outputs("mid_rst");
    check_eq("mid_rst.addr", o_addr, 32'h0);
    check_eq("mid_rst.wdata", o_wdata, 32'h0);
    @(negedge clk);
    arst_n = 1;
    cyc('0);

    // Randomized phases on either instance.
    for (int p = 0; p < 10; p++) begin
      sel = int'($urandom_range(0, 1));
      cap = (sel != 0) ? 4 : 64;
      cyc(mk_start());
      for (int c = 0; c < 80; c++) begin
        cyc(rnd_req());
      end
    end

    cyc('0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Instruction encoder and program loader: the encode direction of the core's opcode-to-control decode path.
- Accepts decoded instruction fields over a valid/ready handshake and assembles 32-bit RV32I/M instruction words.
- Writes the words sequentially into instruction memory through a registered write port.
- Sits between the testbench/boot host and the instruction memory; used to load programs before the core is released.

Parameters:
- ADDR_W, 6, instruction-memory word address width; capacity = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start (ADDR_W bits wide).

Ports:
- clk  input  1  system clock
- arst_n  input  1  asynchronous active-low reset
- start  input  1  pulse: clear counter and errors, enter LOAD
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_op  input  3  class: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH_EQ, 5 JUMP, 6 MUL, 7 undefined
- req_funct3  input  3  funct3 field
- req_rd  input  5  destination register
- req_rs1  input  5  source register 1
- req_rs2  input  5  source register 2
- req_imm  input  21  signed immediate; byte offset for BRANCH_EQ/JUMP
- req_last  input  1  final instruction of the program
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  encoded instruction
- busy  output  1  state != IDLE && state != DONE
- done  output  1  high in DONE
- count  output  ADDR_W+1  words written since start
- err_full  output  1  sticky: request presented while memory full
- err_op  output  1  sticky: undefined req_op accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; write pointer = BASE_ADDR.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> DONE one cycle after an accepted req_last (or on an undefined-op req_last).
  - DONE -> LOAD on start.
  - start in LOAD restarts: count, errors and pointer clear.
- req_ready = (state==LOAD) && !full && !start; full = (count == 2**ADDR_W).
- A start coinciding with req_valid is not accepted; start wins.
- Latency: request accepted in cycle N -> imem_we=1 in cycle N+1 with registered imem_addr/imem_wdata. imem_we is a single-cycle pulse per accepted valid op. Throughput is one word per cycle.
- Pointer increments mod 2**ADDR_W (wraps past BASE_ADDR); count saturates at 2**ADDR_W.
- Encoding (opcode / format):
  - ALU_R 0110011 R, funct7=0.
  - MUL 0110011 R, funct7=0000001.
  - ALU_I 0010011 I, imm[11:0].
  - LOAD 0000011 I.
  - STORE 0100011 S, imm[11:5]/imm[4:0].
  - BRANCH_EQ 1100011 B, funct3 forced 000, imm[12|10:5|4:1|11].
  - JUMP 1101111 J, imm[20|10:1|11|19:12].
  - All other types use req_funct3; unused fields are 0.
- Undefined op (7): accepted (ready high), err_op set, no write, count unchanged.
- Full boundary: req_valid in LOAD while full -> err_full set, request not accepted, state stays LOAD until start.
- Reset mid-operation: a pending write is dropped, imem_we=0 immediately, state IDLE.

Optional Feature:
- Macro NOP_PAD_EN.
- Defined: after the last write, state PAD writes NOP 0x00000013 once per cycle to each remaining address until full, then DONE. busy stays high during PAD; start aborts to LOAD.
- Undefined: no PAD state; DONE follows the last write directly.

Test Plan:
- start; add x3,x1,x2 (op0,f3=0,rd3,rs1=1,rs2=2) -> cycle+1: imem_we=1, addr 0, wdata 0x002081B3, count=1.
- mul x5,x6,x7 (op6) then lw x4,8(x0) (op2,f3=2) back-to-back -> addr 0/1 wdata 0x027302B3/0x00802203 on consecutive cycles.
- sw x4,12(x0) (op3,f3=2) then beq x1,x2,-8 (op4,last=1) -> 0x00402623, 0xFE208CE3; done=1 next cycle; without NOP_PAD_EN count=2.
- ADDR_W=2: five requests -> four writes at 0..3, req_ready=0 after the 4th, err_full=1, fifth never written.
- op7 request -> err_op=1, imem_we stays 0, count unchanged; start -> err_op=0, count=0.
- arst_n low for one cycle during a stream -> all outputs 0, state IDLE; with NOP_PAD_EN, ADDR_W=2, single last request -> addrs 1..3 get 0x00000013, then done.
